// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - PDP-8 opcode, IR field and EA sequencer state definitions
package pdp8_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;

    localparam int IR_OP_HI  = 11;
    localparam int IR_OP_LO  = 9;
    localparam int IR_I_BIT  = 8;
    localparam int IR_Z_BIT  = 7;
    localparam int IR_OFF_HI = 6;

    localparam logic [11:0] AUTO_LO_DEF = 12'o0010;
    localparam logic [11:0] AUTO_HI_DEF = 12'o0017;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IND_RD,
        ST_AUTO_WR,
        ST_JMS_WR,
        ST_DONE
    } ea_state_t;

endpackage

// File: rtl/ea_direct_calc.sv
// rtl/ea_direct_calc.sv - combinational current-page / zero-page direct address former
module ea_direct_calc
    import pdp8_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                  z,
    input  logic [IR_OFF_HI:0]    off,
    input  logic [AW-1:IR_OFF_HI+1] page,
    output logic [AW-1:0]         addr
);

    assign addr = z ? {page, off} : {{(AW-IR_OFF_HI-1){1'b0}}, off};

endmodule

// File: rtl/ea_sequencer.sv
// rtl/ea_sequencer.sv - PDP-8 memory-reference effective-address sequencer
// Optional auto-index increment/write-back enabled by defining EA_AUTOINDEX_EN.
module ea_sequencer
    import pdp8_pkg::*;
#(
    parameter int            AW      = 12,
    parameter logic [AW-1:0] AUTO_LO = AUTO_LO_DEF,
    parameter logic [AW-1:0] AUTO_HI = AUTO_HI_DEF
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          START,
    input  logic [AW-1:0] IR,
    input  logic [AW-1:0] PCLAT,
    input  logic [AW-1:0] RET_PC,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_RD,
    output logic          MEM_WR,
    output logic [AW-1:0] MEM_WDATA,
    input  logic [AW-1:0] MEM_RDATA,
    input  logic          MEM_ACK,
    output logic [AW-1:0] EA,
    output logic          EA_VALID,
    output logic [AW-1:0] PC_IN,
    output logic          PC_LD,
    output logic          BUSY
);

`ifdef EA_AUTOINDEX_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    ea_state_t     state;
    logic [2:0]    op_q;
    logic [AW-1:0] dir_q;
    logic [AW-1:0] ret_q;

    logic [2:0]    ir_op;
    logic [AW-1:0] dir_in;
    logic          start_ok;
    logic          auto_hit;
    logic [AW-1:0] ptr_next;
    logic          enter_done;
    logic [2:0]    done_op;
    logic [AW-1:0] done_ea;

    assign ir_op    = IR[IR_OP_HI:IR_OP_LO];
    assign start_ok = START && (ir_op <= OP_JMP);
    assign auto_hit = AUTO_EN && (dir_q >= AUTO_LO) && (dir_q <= AUTO_HI);
    assign ptr_next = auto_hit ? MEM_RDATA + AW'(1) : MEM_RDATA;

    ea_direct_calc #(.AW(AW)) u_direct (
        .z    (IR[IR_Z_BIT]),
        .off  (IR[IR_OFF_HI:0]),
        .page (PCLAT[AW-1:IR_OFF_HI+1]),
        .addr (dir_in)
    );

    // Detects the edge on which the final EA is known, so the DONE strobes can be registered.
    always_comb begin
        enter_done = 1'b0;
        done_op    = op_q;
        done_ea    = EA;
        case (state)
            ST_IDLE: begin
                done_op    = ir_op;
                done_ea    = dir_in;
                enter_done = start_ok && !IR[IR_I_BIT] && (ir_op != OP_JMS);
            end
            ST_IND_RD: begin
                done_ea    = ptr_next;
                enter_done = MEM_ACK && !auto_hit && (op_q != OP_JMS);
            end
`ifdef EA_AUTOINDEX_EN
            ST_AUTO_WR: enter_done = MEM_ACK && (op_q != OP_JMS);
`endif
            ST_JMS_WR:  enter_done = MEM_ACK;
            default:    enter_done = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            dir_q     <= '0;
            ret_q     <= '0;
            MEM_ADDR  <= '0;
            MEM_RD    <= 1'b0;
            MEM_WR    <= 1'b0;
            MEM_WDATA <= '0;
            EA        <= '0;
            EA_VALID  <= 1'b0;
            PC_IN     <= '0;
            PC_LD     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            EA_VALID <= enter_done && (done_op inside {OP_AND, OP_TAD, OP_ISZ, OP_DCA});
            PC_LD    <= enter_done && ((done_op == OP_JMS) || (done_op == OP_JMP));
            if (enter_done && done_op == OP_JMS)
                PC_IN <= done_ea + AW'(1);
            else if (enter_done && done_op == OP_JMP)
                PC_IN <= done_ea;
            if (enter_done)
                state <= ST_DONE;

            case (state)
                ST_IDLE: if (start_ok) begin
                    op_q     <= ir_op;
                    dir_q    <= dir_in;
                    ret_q    <= RET_PC;
                    EA       <= dir_in;
                    MEM_ADDR <= dir_in;
                    BUSY     <= 1'b1;
                    if (IR[IR_I_BIT]) begin
                        state  <= ST_IND_RD;
                        MEM_RD <= 1'b1;
                    end else if (ir_op == OP_JMS) begin
                        state     <= ST_JMS_WR;
                        MEM_WR    <= 1'b1;
                        MEM_WDATA <= RET_PC;
                    end
                end
                ST_IND_RD: if (MEM_ACK) begin
                    MEM_RD <= 1'b0;
                    EA     <= ptr_next;
`ifdef EA_AUTOINDEX_EN
                    if (auto_hit) begin
                        state     <= ST_AUTO_WR;
                        MEM_WR    <= 1'b1;
                        MEM_WDATA <= ptr_next;
                    end else
`endif
                    if (op_q == OP_JMS) begin
                        state     <= ST_JMS_WR;
                        MEM_WR    <= 1'b1;
                        MEM_ADDR  <= ptr_next;
                        MEM_WDATA <= ret_q;
                    end
                end
`ifdef EA_AUTOINDEX_EN
                ST_AUTO_WR: if (MEM_ACK) begin
                    // Write strobe stays high: the JMS return store follows back to back.
                    if (op_q == OP_JMS) begin
                        state     <= ST_JMS_WR;
                        MEM_ADDR  <= EA;
                        MEM_WDATA <= ret_q;
                    end else begin
                        MEM_WR <= 1'b0;
                    end
                end
`endif
                ST_JMS_WR: if (MEM_ACK) MEM_WR <= 1'b0;
                ST_DONE: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ea_sequencer.sv
// tb/tb_ea_sequencer.sv - directed self-checking bench for ea_sequencer with a memory responder
module tb_ea_sequencer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        START = 1'b0;
    logic [11:0] IR = '0, PCLAT = '0, RET_PC = '0;
    logic [11:0] MEM_ADDR, MEM_WDATA, EA, PC_IN;
    logic [11:0] MEM_RDATA = '0;
    logic        MEM_RD, MEM_WR, MEM_ACK = 1'b0;
    logic        EA_VALID, PC_LD, BUSY;

    always #5 CLK = ~CLK;

    ea_sequencer dut (
        .CLK(CLK), .CLR(CLR), .START(START), .IR(IR), .PCLAT(PCLAT), .RET_PC(RET_PC),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .EA(EA), .EA_VALID(EA_VALID),
        .PC_IN(PC_IN), .PC_LD(PC_LD), .BUSY(BUSY)
    );

    logic [11:0] mem [0:4095];
    int ack_delay = 1;
    int req_cnt = 0, rd_cnt = 0, wr_cnt = 0, req_hi = 0, unstable = 0, overlap = 0;
    logic [11:0] last_ra = '0, last_wa = '0, last_wd = '0, req_addr = '0, req_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Memory responder: acks after ack_delay request cycles, checks request stability.
    always @(negedge CLK) begin
        if (MEM_RD && MEM_WR) overlap++;
        if (MEM_ACK) begin
            MEM_ACK = 1'b0;
            req_cnt = 0;
        end
        if (MEM_RD || MEM_WR) begin
            req_hi++;
            if (req_cnt == 0) begin
                req_addr = MEM_ADDR;
                req_data = MEM_WDATA;
            end else if (MEM_ADDR !== req_addr || (MEM_WR && MEM_WDATA !== req_data)) begin
                unstable++;
            end
            req_cnt++;
            if (req_cnt >= ack_delay) begin
                MEM_ACK = 1'b1;
                if (MEM_RD) begin
                    MEM_RDATA = mem[MEM_ADDR];
                    last_ra   = MEM_ADDR;
                    rd_cnt++;
                end else begin
                    mem[MEM_ADDR] = MEM_WDATA;
                    last_wa = MEM_ADDR;
                    last_wd = MEM_WDATA;
                    wr_cnt++;
                end
            end
        end else begin
            req_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [11:0] ir, input logic [11:0] pc, input logic [11:0] ret);
        IR = ir; PCLAT = pc; RET_PC = ret; START = 1'b1;
        tick();
        START = 1'b0; IR = 12'o7777; PCLAT = 12'o7777; RET_PC = 12'o7777;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!(EA_VALID || PC_LD) && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, r0, w0, h0;

        repeat (3) tick();
        check("rst_busy", BUSY, 0);
        check("rst_rd", MEM_RD, 0);
        check("rst_wr", MEM_WR, 0);
        check("rst_ea", EA, 0);
        check("rst_eav", EA_VALID, 0);
        check("rst_pcld", PC_LD, 0);
        check("rst_pcin", PC_IN, 0);
        CLR = 1'b0;
        tick();

        // Direct JMP, current page
        h0 = req_hi;
        issue(12'o5205, 12'o0400, 12'o0401);
        wait_done(lat);
        check("jmp_lat", lat, 1);
        check("jmp_pcld", PC_LD, 1);
        check("jmp_pcin", PC_IN, 12'o0405);
        check("jmp_eav", EA_VALID, 0);
        check("jmp_busy", BUSY, 1);
        tick();
        check("jmp_pcld_drop", PC_LD, 0);
        check("jmp_busy_drop", BUSY, 0);
        check("jmp_noreq", req_hi - h0, 0);

        // Direct TAD, current page
        h0 = req_hi;
        issue(12'o1250, 12'o0200, 12'o0201);
        wait_done(lat);
        check("dtad_lat", lat, 1);
        check("dtad_eav", EA_VALID, 1);
        check("dtad_ea", EA, 12'o0250);
        check("dtad_noreq", req_hi - h0, 0);
        tick();

        // Indirect TAD through 0250
        mem[12'o0250] = 12'o3456;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(12'o1650, 12'o0200, 12'o0201);
        check("itad_rd", MEM_RD, 1);
        check("itad_addr", MEM_ADDR, 12'o0250);
        wait_done(lat);
        check("itad_lat", lat, 2);
        check("itad_eav", EA_VALID, 1);
        check("itad_ea", EA, 12'o3456);
        check("itad_nrd", rd_cnt - r0, 1);
        check("itad_ra", last_ra, 12'o0250);
        check("itad_nwr", wr_cnt - w0, 0);
        tick(); tick();
        check("itad_ea_hold", EA, 12'o3456);
        check("itad_eav_drop", EA_VALID, 0);

        // Auto-index through 0010
        mem[12'o0010] = 12'o0777;
        w0 = wr_cnt;
        issue(12'o1410, 12'o0200, 12'o0201);
        wait_done(lat);
`ifdef EA_AUTOINDEX_EN
        check("auto_lat", lat, 3);
        check("auto_ea", EA, 12'o1000);
        check("auto_nwr", wr_cnt - w0, 1);
        check("auto_wa", last_wa, 12'o0010);
        check("auto_mem", mem[12'o0010], 12'o1000);
`else
        check("auto_lat", lat, 2);
        check("auto_ea", EA, 12'o0777);
        check("auto_nwr", wr_cnt - w0, 0);
        check("auto_mem", mem[12'o0010], 12'o0777);
`endif
        check("auto_eav", EA_VALID, 1);
        tick();

        // Auto-index wrap at 7777
        mem[12'o0017] = 12'o7777;
        issue(12'o1417, 12'o0000, 12'o0001);
        wait_done(lat);
`ifdef EA_AUTOINDEX_EN
        check("wrap_ea", EA, 12'o0000);
        check("wrap_mem", mem[12'o0017], 12'o0000);
`else
        check("wrap_ea", EA, 12'o7777);
        check("wrap_mem", mem[12'o0017], 12'o7777);
`endif
        tick();

        // Auto-index JMS: pointer write then return-address store
        mem[12'o0010] = 12'o0500;
        w0 = wr_cnt;
        issue(12'o4410, 12'o0300, 12'o0301);
        wait_done(lat);
`ifdef EA_AUTOINDEX_EN
        check("ajms_lat", lat, 4);
        check("ajms_pcin", PC_IN, 12'o0502);
        check("ajms_nwr", wr_cnt - w0, 2);
        check("ajms_ret", mem[12'o0501], 12'o0301);
        check("ajms_ptr", mem[12'o0010], 12'o0501);
`else
        check("ajms_lat", lat, 3);
        check("ajms_pcin", PC_IN, 12'o0501);
        check("ajms_nwr", wr_cnt - w0, 1);
        check("ajms_ret", mem[12'o0500], 12'o0301);
`endif
        check("ajms_pcld", PC_LD, 1);
        check("ajms_eav", EA_VALID, 0);
        tick();

        // JMS with ack after 3 cycles, plus a START while busy
        ack_delay = 3;
        h0 = req_hi;
        issue(12'o4220, 12'o0200, 12'o0201);
        check("djms_wr", MEM_WR, 1);
        check("djms_addr", MEM_ADDR, 12'o0220);
        check("djms_wdata", MEM_WDATA, 12'o0201);
        IR = 12'o5000; START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(lat);
        check("djms_lat", lat + 1, 4);
        check("djms_pcld", PC_LD, 1);
        check("djms_pcin", PC_IN, 12'o0221);
        check("djms_held", req_hi - h0, 3);
        check("djms_stable", unstable, 0);
        check("djms_mem", mem[12'o0220], 12'o0201);
        tick();
        check("djms_busy_drop", BUSY, 0);
        tick();
        check("djms_no_relaunch", BUSY, 0);
        ack_delay = 1;

        // Opcode 6 START is ignored
        issue(12'o6205, 12'o0200, 12'o0201);
        check("iot_busy", BUSY, 0);
        tick();
        check("iot_busy2", BUSY, 0);
        check("iot_pcld", PC_LD, 0);
        check("iot_eav", EA_VALID, 0);

        // Reset during an unacknowledged indirect read
        ack_delay = 100;
        issue(12'o1650, 12'o0200, 12'o0201);
        check("rmid_rd", MEM_RD, 1);
        tick();
        CLR = 1'b1;
        tick();
        check("rmid_rd_drop", MEM_RD, 0);
        check("rmid_busy", BUSY, 0);
        check("rmid_ea", EA, 0);
        CLR = 1'b0;
        ack_delay = 1;
        tick();
        issue(12'o0105, 12'o0200, 12'o0201);
        wait_done(lat);
        check("rmid_and_lat", lat, 1);
        check("rmid_and_eav", EA_VALID, 1);
        check("rmid_and_ea", EA, 12'o0105);
        tick(); tick();

        check("rd_wr_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
